reg_wb_scoreboard: RTL and testbench
====================================

# reg_wb_scoreboard

Parametrised writeback-address controller and register scoreboard for the pipelined MIPS core. It decodes each issued instruction's destination register and write enable, carries them down a DEPTH-stage shift pipeline to the register-file write port, and tracks in-flight destinations so it can raise a RAW-hazard stall at decode. The block sits between decode/issue and the register file, and supports a pipeline flush.

## Interface
- ADDR_W, 5: register address width (2^ADDR_W registers).
- DEPTH, 3: number of stages from issue to register-file write, including the writeback stage; DEPTH >= 1.
- LINK_REG, 31: destination register for jump-and-link.
- BYPASS_WB, 0: 1 means the register file is write-through, so the writeback slot is excluded from hazard checks.

- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- alu_op, imm_op, jump_op, link, mem_op, store_op  in  1 each  instruction class flags.
- rs, rt, rd  in  ADDR_W each  instruction register fields.
- flush  in  1  kill all non-writeback in-flight entries and the current issue.
- stall  out  1  combinational: issue_valid is blocked by a hazard.
- wb_en  out  1  register-file write enable (registered).
- wb_addr  out  ADDR_W  register-file write address (registered).
- pending  out  $clog2(DEPTH+1)  count of valid in-flight entries (registered).

## Operation
- Destination decode, in priority order:
  - mem_op & ~store_op gives rt.
  - alu_op & imm_op gives rt.
  - jump_op & link gives LINK_REG.
  - alu_op gives rd.
  - Anything else gives no write.
- Entry valid: issue_valid & ~stall & ~flush & decoded write exists & dest != 0. A write to r0 is dropped; it produces a bubble, not an entry.
- Slots s[0..DEPTH-1] each hold {valid, addr}. s[DEPTH-1] is the writeback slot: wb_en = s[DEPTH-1].valid and wb_addr = s[DEPTH-1].addr. When wb_en = 0, wb_addr holds the value 0.
- Every cycle, s[i+1] <= s[i] and s[0] <= the new entry or a bubble. The pipeline never freezes; a stall inserts a bubble.
- Hazard: for each valid slot i, with i < DEPTH-1 when BYPASS_WB=1, compare its addr against rs and against rt. Sources equal to 0 never match. stall = issue_valid & ~flush & any match.
- Flush: on the next edge s[1..DEPTH-1] are all loaded invalid and s[0] gets a bubble. The wb outputs during the flush cycle are the already-registered s[DEPTH-1] and are unaffected. stall is forced to 0 during flush.
- pending = number of valid slots after the edge.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): all slots invalid, wb_en=0, wb_addr=0, pending=0. stall=0 while reset_n=0.
- Latency: an entry accepted at edge t drives wb_en at edge t+DEPTH-1, so it is visible for the cycle after that edge. With DEPTH=1, the entry accepted at an edge is presented immediately after it.
- stall depends only on current inputs and registered slots; there is no same-cycle self-hazard on the instruction being issued.
- Back-to-back issue to the same destination with no source overlap produces no stall; both entries coexist.
- Simultaneous flush and hazard: flush wins, stall=0 and nothing is inserted.
- reset_n asserted mid-operation clears everything immediately; in-flight writes are lost.

## Test plan
- Reset, then issue addi (alu_op=1, imm_op=1, rt=8, rd=3), DEPTH=3 -> wb_en=1, wb_addr=8 two edges after acceptance; pending goes 1,1,1,0.
- Issue lw rt=5, then `add rs=5` next cycle -> stall=1 for the next two cycles (three with BYPASS_WB=0 and the writeback slot included); the add is accepted once slot 5 retires.
- Issue jal (jump_op=1, link=1) -> wb_addr=31. Issue sw (mem_op=1, store_op=1) -> no entry, pending unchanged.
- Issue alu rd=0 -> no entry, and a subsequent instruction with rs=0 never stalls.
- Fill three entries (regs 4, 5, 6), assert flush while reg 6 is in the writeback slot -> reg 6 written this cycle, then wb_en=0 and pending=0.
- Assert reset_n=0 mid-stream with pending=2 -> wb_en, wb_addr and pending clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/reg_wb_scoreboard.sv
// Writeback-address pipeline and register scoreboard: decodes each issued
// destination, shifts it to the register-file write port and flags RAW hazards.
module reg_wb_scoreboard #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned LINK_REG  = 31,
    parameter int unsigned BYPASS_WB = 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         issue_valid,
    input  logic                         alu_op,
    input  logic                         imm_op,
    input  logic                         jump_op,
    input  logic                         link,
    input  logic                         mem_op,
    input  logic                         store_op,
    input  logic [ADDR_W-1:0]            rs,
    input  logic [ADDR_W-1:0]            rt,
    input  logic [ADDR_W-1:0]            rd,
    input  logic                         flush,
    output logic                         stall,
    output logic                         wb_en,
    output logic [ADDR_W-1:0]            wb_addr,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    // With a write-through register file the writeback slot cannot cause a hazard.
    localparam int unsigned CHK_N = (BYPASS_WB != 0) ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]             pending_q, pending_d;

    logic [ADDR_W-1:0] dest;
    logic              has_wr;
    logic              hit;
    logic              accept;

    // Destination decode in priority order.
    always_comb begin
        dest   = '0;
        has_wr = 1'b0;
        if (mem_op && !store_op) begin
            dest   = rt;
            has_wr = 1'b1;
        end else if (alu_op && imm_op) begin
            dest   = rt;
            has_wr = 1'b1;
        end else if (jump_op && link) begin
            dest   = ADDR_W'(LINK_REG);
            has_wr = 1'b1;
        end else if (alu_op) begin
            dest   = rd;
            has_wr = 1'b1;
        end
    end

    // Source match against in-flight destinations; r0 sources never match.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < CHK_N && vld_q[i]) begin
                if ((rs != '0 && addr_q[i] == rs) || (rt != '0 && addr_q[i] == rt)) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign stall  = issue_valid && !flush && hit;
    assign accept = issue_valid && !stall && !flush && has_wr && (dest != '0);

    always_comb begin
        vld_d     = '0;
        addr_d    = '0;
        pending_d = '0;
        vld_d[0]  = accept;
        addr_d[0] = accept ? dest : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_d[i]  = flush ? 1'b0 : vld_q[i-1];
            addr_d[i] = flush ? '0   : addr_q[i-1];
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pending_d = pending_d + CNT_W'(vld_d[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q     <= '0;
            addr_q    <= '0;
            pending_q <= '0;
        end else begin
            vld_q     <= vld_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
        end
    end

    assign wb_en   = vld_q[DEPTH-1];
    assign wb_addr = addr_q[DEPTH-1];
    assign pending = pending_q;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Randomized and directed checks of reg_wb_scoreboard against a list-of-in-flight-writes model.
module tb_reg_wb_scoreboard;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DEPTH    = 3;
    localparam int unsigned LINK_REG = 31;
    localparam int unsigned BYPASS   = 0;
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset_n;
    logic              issue_valid, alu_op, imm_op, jump_op, link, mem_op, store_op, flush;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic              stall, wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [CW-1:0]     pending;

    int total = 0;
    int bad   = 0;

    // In-flight writes: destination and edges elapsed since acceptance.
    int q_addr[$];
    int q_age[$];

    reg_wb_scoreboard #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LINK_REG(LINK_REG), .BYPASS_WB(BYPASS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid),
        .alu_op(alu_op), .imm_op(imm_op), .jump_op(jump_op), .link(link),
        .mem_op(mem_op), .store_op(store_op), .rs(rs), .rt(rt), .rd(rd),
        .flush(flush), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
        .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_dest();
        if (mem_op && !store_op) return int'(rt);
        if (alu_op && imm_op)    return int'(rt);
        if (jump_op && link)     return int'(LINK_REG);
        if (alu_op)              return int'(rd);
        return 0;
    endfunction

    function automatic logic model_stall();
        if (!issue_valid || flush) return 1'b0;
        foreach (q_addr[k]) begin
            if (BYPASS == 0 || q_age[k] < int'(DEPTH) - 1) begin
                if ((rs != 0 && q_addr[k] == int'(rs)) || (rt != 0 && q_addr[k] == int'(rt)))
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic cycle(input logic iv, input logic a, input logic im, input logic jo,
                         input logic lk, input logic mo, input logic so,
                         input logic [ADDR_W-1:0] s_rs, input logic [ADDR_W-1:0] s_rt,
                         input logic [ADDR_W-1:0] s_rd, input logic fl);
        logic es;
        int   d;
        int   ew_en, ew_addr;
        int   na[$];
        int   ng[$];
        @(negedge clock);
        issue_valid = iv; alu_op = a; imm_op = im; jump_op = jo; link = lk;
        mem_op = mo; store_op = so; rs = s_rs; rt = s_rt; rd = s_rd; flush = fl;
        #1;
        es = model_stall();
        check("stall", int'(stall), int'(es));
        d = model_dest();
        @(posedge clock);
        foreach (q_addr[k]) begin
            if (!fl && q_age[k] + 1 <= int'(DEPTH) - 1) begin
                na.push_back(q_addr[k]);
                ng.push_back(q_age[k] + 1);
            end
        end
        if (iv && !fl && !es && d > 0) begin
            na.push_back(d);
            ng.push_back(0);
        end
        q_addr = na;
        q_age  = ng;
        #1;
        ew_en = 0; ew_addr = 0;
        foreach (q_addr[k]) if (q_age[k] == int'(DEPTH) - 1) begin
            ew_en = 1; ew_addr = q_addr[k];
        end
        check("wb_en", int'(wb_en), ew_en);
        check("wb_addr", int'(wb_addr), ew_addr);
        check("pending", int'(pending), q_addr.size());
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic alu_rd(input logic [ADDR_W-1:0] r_s, input logic [ADDR_W-1:0] r_d);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r_s, 5'd0, r_d, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        issue_valid = 1'b0; alu_op = 1'b0; imm_op = 1'b0; jump_op = 1'b0; link = 1'b0;
        mem_op = 1'b0; store_op = 1'b0; rs = '0; rt = '0; rd = '0; flush = 1'b0;
        #3;
        check("rst_wb_en", int'(wb_en), 0);
        check("rst_wb_addr", int'(wb_addr), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_stall", int'(stall), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // addi rt=8, rd=3
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd3, 1'b0);
        repeat (3) idle();
        // lw rt=5 then add rs=5 held until accepted
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 5'd0, 1'b0);
        repeat (4) alu_rd(5'd5, 5'd9);
        repeat (3) idle();
        // jal, then sw (no entry)
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd3, 5'd0, 1'b0);
        repeat (2) idle();
        // write to r0 is dropped; rs=0 never stalls
        alu_rd(5'd0, 5'd0);
        alu_rd(5'd0, 5'd7);
        repeat (3) idle();
        // fill, flush while reg 6 is at writeback, with a hazarding issue alongside
        alu_rd(5'd0, 5'd4);
        alu_rd(5'd0, 5'd5);
        alu_rd(5'd0, 5'd6);
        alu_rd(5'd0, 5'd7);
        alu_rd(5'd0, 5'd8);
        check("flush_pre_wb", int'(wb_addr), 6);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd7, 5'd9, 1'b1);
        check("flush_post_pending", int'(pending), 0);
        idle();

        // asynchronous reset mid-stream with two entries in flight
        alu_rd(5'd0, 5'd10);
        alu_rd(5'd0, 5'd11);
        check("pre_rst_pending", int'(pending), 2);
        @(negedge clock);
        issue_valid = 1'b1; alu_op = 1'b1; rs = 5'd10; rt = 5'd11; rd = 5'd12;
        #2 reset_n = 1'b0;
        #1;
        check("async_wb_en", int'(wb_en), 0);
        check("async_wb_addr", int'(wb_addr), 0);
        check("async_pending", int'(pending), 0);
        check("async_stall", int'(stall), 0);
        q_addr.delete();
        q_age.delete();
        @(negedge clock);
        reset_n = 1'b1;

        // randomized traffic over a small register range to provoke hazards
        for (int n = 0; n < 500; n++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 11) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
